// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, stall/flush, per-channel write enables
// and a saturating stall counter. Define PIPE_SKID_BUFFER_EN to add a one-entry skid buffer.
module pipe_stage_reg #(
   parameter int                 WIDTH       = 32,
   parameter int                 CHANNELS    = 2,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
   parameter int                 CNT_W       = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CHANNELS*WIDTH-1:0]    in_data,
   input  logic [CHANNELS-1:0]          chan_we,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CHANNELS*WIDTH-1:0]    out_data,
   input  logic                         stall,
   input  logic                         flush,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int DW = CHANNELS * WIDTH;

   // Handshake: a beat moves across a port on a rising edge where valid && ready are both high;
   // the producer holds valid and data stable until that edge, ready never waits on valid.

   function automatic logic [DW-1:0] merge(input logic [DW-1:0]       old_d,
                                            input logic [DW-1:0]       new_d,
                                            input logic [CHANNELS-1:0] we);
      logic [DW-1:0] r;
      r = old_d;
      for (int k = 0; k < CHANNELS; k++) begin
         if (we[k]) r[k*WIDTH +: WIDTH] = new_d[k*WIDTH +: WIDTH];
      end
      return r;
   endfunction

   logic accept;
   logic main_free;

   assign accept    = in_valid && in_ready && !flush;
   assign main_free = !out_valid || out_ready;

`ifdef PIPE_SKID_BUFFER_EN
   logic                skid_valid;
   logic [DW-1:0]       skid_data;
   logic [CHANNELS-1:0] skid_we;

   // in_ready depends only on state and stall, never on out_ready.
   assign in_ready = !skid_valid && !stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= {CHANNELS{RESET_VALUE}};
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_we    <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!stall) begin
         if (skid_valid) begin
            if (main_free) begin
               out_valid  <= 1'b1;
               out_data   <= merge(out_data, skid_data, skid_we);
               skid_valid <= 1'b0;
            end
         end else if (accept) begin
            if (main_free) begin
               out_valid <= 1'b1;
               out_data  <= merge(out_data, in_data, chan_we);
            end else begin
               skid_valid <= 1'b1;
               skid_data  <= in_data;
               skid_we    <= chan_we;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
`else
   assign in_ready = !stall && main_free;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= {CHANNELS{RESET_VALUE}};
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (!stall) begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= merge(out_data, in_data, chan_we);
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table for single-cycle behaviour plus hand sequences
// for asynchronous reset, counter saturation and (when PIPE_SKID_BUFFER_EN is defined) the skid path.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_BUFFER_EN
   localparam bit SKID_MODE = 1'b1;
`else
   localparam bit SKID_MODE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, stall, flush;
   logic [63:0] in_data, out_data;
   logic [1:0]  chan_we;
   logic [15:0] stall_cnt;

   logic        in_ready2, out_valid2, stall2;
   logic [7:0]  out_data2;
   logic [2:0]  stall_cnt2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .chan_we(chan_we), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall(stall), .flush(flush), .stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.WIDTH(8), .CHANNELS(1), .CNT_W(3)) dut_small (
      .clk(clk), .reset(reset), .in_valid(1'b0), .in_ready(in_ready2), .in_data(8'h00),
      .chan_we(1'b1), .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
      .stall(stall2), .flush(1'b0), .stall_cnt(stall_cnt2)
   );

   typedef struct {
      logic        iv;
      logic [31:0] d0, d1;
      logic [1:0]  we;
      logic        ordy, stl, fl;
      logic        e_rdy, e_v;
      logic [31:0] e_d0, e_d1;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic iv, logic [31:0] d0, logic [31:0] d1, logic [1:0] we,
                               logic ordy, logic stl, logic fl, logic e_rdy, logic e_v,
                               logic [31:0] e_d0, logic [31:0] e_d1, logic [15:0] e_cnt);
      vec_t v;
      v.iv = iv; v.d0 = d0; v.d1 = d1; v.we = we; v.ordy = ordy; v.stl = stl; v.fl = fl;
      v.e_rdy = e_rdy; v.e_v = e_v; v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] we, input logic ordy, input logic stl, input logic fl);
      in_valid  = iv;
      in_data   = {d1, d0};
      chan_we   = we;
      out_ready = ordy;
      stall     = stl;
      flush     = fl;
   endtask

   initial begin
      reset = 1'b1;
      stall2 = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset out_valid", {63'd0, out_valid}, 64'd0);
      check("reset out_data", out_data, 64'd0);
      check("reset stall_cnt", {48'd0, stall_cnt}, 64'd0);
      reset = 1'b0;
      #1 check("reset in_ready", {63'd0, in_ready}, 64'd1);

      // iv, d0, d1, we, ordy, stall, flush | in_ready, out_valid, ch0, ch1, stall_cnt
      vecs.push_back(mk(1, 32'h00,  32'h04,  2'b11, 1, 0, 0, 1, 1, 32'h00,  32'h04,  0));
      vecs.push_back(mk(1, 32'h04,  32'h08,  2'b11, 1, 0, 0, 1, 1, 32'h04,  32'h08,  0));
      vecs.push_back(mk(1, 32'h08,  32'h0C,  2'b11, 1, 0, 0, 1, 1, 32'h08,  32'h0C,  0));
      vecs.push_back(mk(0, 32'h00,  32'h00,  2'b11, 1, 0, 0, 1, 0, 32'h08,  32'h0C,  0));
      vecs.push_back(mk(1, 32'h100, 32'h104, 2'b11, 0, 0, 0, 1, 1, 32'h100, 32'h104, 0));
      vecs.push_back(mk(1, 32'h200, 32'h204, 2'b01, 1, 0, 0, 1, 1, 32'h200, 32'h104, 0));
      vecs.push_back(mk(0, 32'h00,  32'h00,  2'b11, 0, 0, 0, SKID_MODE, 1, 32'h200, 32'h104, 0));
      vecs.push_back(mk(1, 32'h40,  32'h44,  2'b11, 1, 0, 0, 1, 1, 32'h40,  32'h44,  0));
      for (int i = 1; i <= 5; i++)
         vecs.push_back(mk(1, 32'h99, 32'h99, 2'b11, 1, 1, 0, 0, 1, 32'h40, 32'h44, 16'(i)));
      vecs.push_back(mk(1, 32'h80,  32'h84,  2'b11, 0, 1, 1, 0, 0, 32'h40,  32'h44,  5));
      vecs.push_back(mk(1, 32'h90,  32'h94,  2'b11, 0, 0, 1, 1, 0, 32'h40,  32'h44,  5));
      vecs.push_back(mk(1, 32'hAA,  32'hBB,  2'b00, 0, 0, 0, 1, 1, 32'h40,  32'h44,  5));
      vecs.push_back(mk(0, 32'h00,  32'h00,  2'b11, 1, 1, 0, 0, 1, 32'h40,  32'h44,  6));
      vecs.push_back(mk(0, 32'h00,  32'h00,  2'b11, 1, 0, 0, 1, 0, 32'h40,  32'h44,  6));

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].iv, vecs[i].d0, vecs[i].d1, vecs[i].we, vecs[i].ordy, vecs[i].stl, vecs[i].fl);
         #1 check($sformatf("vec%0d in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_rdy});
         @(posedge clk);
         #1;
         check($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_v});
         check($sformatf("vec%0d out_data", i), out_data, {vecs[i].e_d1, vecs[i].e_d0});
         check($sformatf("vec%0d stall_cnt", i), {48'd0, stall_cnt}, {48'd0, vecs[i].e_cnt});
      end

      // asynchronous reset while a beat is held
      @(negedge clk);
      drive(1'b1, 32'hDEADBEEF, 32'h00000004, 2'b11, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 check("pre-reset out_data", out_data, {32'h00000004, 32'hDEADBEEF});
      check("pre-reset out_valid", {63'd0, out_valid}, 64'd1);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("async reset out_valid", {63'd0, out_valid}, 64'd0);
      check("async reset out_data", out_data, 64'd0);
      check("async reset stall_cnt", {48'd0, stall_cnt}, 64'd0);
      check("async reset in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      reset = 1'b0;

      // 3-bit counter saturation
      @(negedge clk);
      stall2 = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("cnt3 after 6", {61'd0, stall_cnt2}, 64'd6);
      repeat (4) @(posedge clk);
      #1 check("cnt3 saturated", {61'd0, stall_cnt2}, 64'd7);
      check("cnt3 in_ready stalled", {63'd0, in_ready2}, 64'd0);
      @(negedge clk);
      stall2 = 1'b0;

`ifdef PIPE_SKID_BUFFER_EN
      @(negedge clk);
      drive(1'b1, 32'h10, 32'h11, 2'b11, 1'b0, 1'b0, 1'b0);
      #1 check("skid rdy0", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      drive(1'b1, 32'h14, 32'h15, 2'b11, 1'b0, 1'b0, 1'b0);
      #1 check("skid rdy1", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      check("skid full in_ready", {63'd0, in_ready}, 64'd0);
      check("skid main data", out_data, {32'h11, 32'h10});
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("skid second beat", out_data, {32'h15, 32'h14});
      check("skid second valid", {63'd0, out_valid}, 64'd1);
      check("skid drained rdy", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1 check("skid empty valid", {63'd0, out_valid}, 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
